// File: rtl/traffic_phase_sequencer.sv
// Round-robin traffic signal phase sequencer: GREEN -> YELLOW -> ALLRED per phase, tick-timed.
// Optional emergency preemption toward phase 0 is built when TRAFFIC_PREEMPT_EN is defined.
module traffic_phase_sequencer #(
    parameter int NUM_PHASES  = 4,
    parameter int MIN_GREEN   = 3,
    parameter int MAX_GREEN   = 8,
    parameter int YELLOW_TIME = 2,
    parameter int ALLRED_TIME = 1,
    localparam int PW = $clog2(NUM_PHASES),
    localparam int RW = $clog2(MAX_GREEN + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
`ifdef TRAFFIC_PREEMPT_EN
    input  logic                  preempt,
`endif
    input  logic [NUM_PHASES-1:0] demand,
    output logic [NUM_PHASES-1:0] green,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] red,
    output logic [PW-1:0]         active_phase,
    output logic [RW-1:0]         remaining
);

    // The interval counter must also hold yellow/all-red lengths, which may exceed MAX_GREEN.
    localparam int TMAX_A = (MAX_GREEN > YELLOW_TIME) ? MAX_GREEN : YELLOW_TIME;
    localparam int TMAX   = (TMAX_A > ALLRED_TIME) ? TMAX_A : ALLRED_TIME;
    localparam int CW     = $clog2(TMAX + 1);

    typedef enum logic [1:0] {
        S_GREEN  = 2'd0,
        S_YELLOW = 2'd1,
        S_ALLRED = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q, count_d;
    logic [PW-1:0]         active_q, active_d;
    logic [PW-1:0]         next_q, next_d;
    logic [NUM_PHASES-1:0] pending_q, pending_d;

    logic [NUM_PHASES-1:0] green_d, yellow_d, red_d, onehot_d;
    logic [RW-1:0]         remaining_d;

    logic                  found;
    logic [PW-1:0]         rr_sel;
    logic [PW-1:0]         rr_idx;
    logic [CW-1:0]         green_inc;
    logic [CW-1:0]         count_inc;
    logic                  held;
    logic                  exit_ok;
    logic                  preempt_req;

`ifdef TRAFFIC_PREEMPT_EN
    assign preempt_req = preempt;
`else
    assign preempt_req = 1'b0;
`endif

    // First pending phase after the active one; the active bit is never pending during its green.
    always_comb begin
        found  = 1'b0;
        rr_sel = '0;
        rr_idx = '0;
        for (int k = 1; k < NUM_PHASES; k++) begin
            rr_idx = PW'((int'(active_q) + k) % NUM_PHASES);
            if (!found && pending_q[rr_idx]) begin
                found  = 1'b1;
                rr_sel = rr_idx;
            end
        end
    end

    assign green_inc = (count_q >= CW'(MAX_GREEN)) ? CW'(MAX_GREEN) : count_q + CW'(1);
    assign count_inc = count_q + CW'(1);
    assign held      = demand[active_q];

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        active_d  = active_q;
        next_d    = next_q;
        pending_d = pending_q | demand;
        exit_ok   = 1'b0;

        case (state_q)
            S_GREEN: begin
                pending_d[active_q] = pending_q[active_q];
                if (tick) begin
                    count_d = green_inc;
                    exit_ok = (green_inc >= CW'(MIN_GREEN)) && found &&
                              (!held || (green_inc == CW'(MAX_GREEN)));
                    if (preempt_req) begin
                        exit_ok = (active_q != '0);
                    end
                    if (exit_ok) begin
                        state_d = S_YELLOW;
                        count_d = '0;
                        next_d  = preempt_req ? '0 : rr_sel;
                    end
                end
            end
            S_YELLOW: begin
                if (preempt_req) begin
                    next_d = '0;
                end
                if (tick) begin
                    if (count_inc == CW'(YELLOW_TIME)) begin
                        state_d = S_ALLRED;
                        count_d = '0;
                    end else begin
                        count_d = count_inc;
                    end
                end
            end
            S_ALLRED: begin
                if (preempt_req) begin
                    next_d = '0;
                end
                if (tick) begin
                    if (count_inc == CW'(ALLRED_TIME)) begin
                        state_d  = S_GREEN;
                        count_d  = '0;
                        active_d = next_d;
                        pending_d[next_d] = 1'b0;
                    end else begin
                        count_d = count_inc;
                    end
                end
            end
            default: begin
                state_d = S_GREEN;
                count_d = '0;
            end
        endcase
    end

    // Lamp and status flops load the decode of the next state, so they track the state register.
    always_comb begin
        onehot_d    = {{(NUM_PHASES-1){1'b0}}, 1'b1} << active_d;
        green_d     = '0;
        yellow_d    = '0;
        remaining_d = '0;
        case (state_d)
            S_GREEN: begin
                green_d     = onehot_d;
                remaining_d = RW'(MAX_GREEN) - RW'(count_d);
            end
            S_YELLOW: begin
                yellow_d    = onehot_d;
                remaining_d = RW'(YELLOW_TIME) - RW'(count_d);
            end
            S_ALLRED: begin
                remaining_d = RW'(ALLRED_TIME) - RW'(count_d);
            end
            default: begin
                remaining_d = '0;
            end
        endcase
        red_d = ~(green_d | yellow_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_GREEN;
            count_q      <= '0;
            active_q     <= '0;
            next_q       <= '0;
            pending_q    <= '0;
            green        <= {{(NUM_PHASES-1){1'b0}}, 1'b1};
            yellow       <= '0;
            red          <= ~{{(NUM_PHASES-1){1'b0}}, 1'b1};
            active_phase <= '0;
            remaining    <= RW'(MAX_GREEN);
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            active_q     <= active_d;
            next_q       <= next_d;
            pending_q    <= pending_d;
            green        <= green_d;
            yellow       <= yellow_d;
            red          <= red_d;
            active_phase <= active_d;
            remaining    <= remaining_d;
        end
    end

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Self-checking bench for traffic_phase_sequencer (4 phases, MIN=3, MAX=8, Y=2, AR=1).
// Preemption scenario is exercised only when TRAFFIC_PREEMPT_EN is defined.
module tb_traffic_phase_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic [3:0] demand = 4'b0;
    logic [3:0] green, yellow, red;
    logic [1:0] active_phase;
    logic [3:0] remaining;
`ifdef TRAFFIC_PREEMPT_EN
    logic       preempt = 1'b0;
`endif

    int total = 0;
    int passed = 0;

    traffic_phase_sequencer #(
        .NUM_PHASES(4), .MIN_GREEN(3), .MAX_GREEN(8), .YELLOW_TIME(2), .ALLRED_TIME(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
`ifdef TRAFFIC_PREEMPT_EN
        .preempt(preempt),
`endif
        .demand(demand),
        .green(green),
        .yellow(yellow),
        .red(red),
        .active_phase(active_phase),
        .remaining(remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [3:0] rem;
        logic [1:0] act;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       tk;
        logic [3:0] dm;
        byte        st;
        int         ph;
        int         rem;
    } vec_t;

    exp_t  exp_q[$];
    string tag_q[$];
    vec_t  vecs[17];

    function automatic exp_t expect_of(input byte st, input int ph, input int rem);
        exp_t       e;
        logic [3:0] oh;
        oh = 4'b0001 << ph;
        e.g = 4'b0;
        e.y = 4'b0;
        if (st == "G") e.g = oh;
        if (st == "Y") e.y = oh;
        e.r   = ~(e.g | e.y);
        e.rem = 4'(rem);
        e.act = 2'(ph);
        return e;
    endfunction

    // Drive one cycle of inputs, queue the lamp state expected after the edge, then compare.
    task automatic step(input logic rst, input logic tk, input logic [3:0] dm,
                        input byte st, input int ph, input int rem, input string tag);
        exp_t e;
        reset  = rst;
        tick   = tk;
        demand = dm;
        exp_q.push_back(expect_of(st, ph, rem));
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            void'(tag_q.pop_front());
            if (green === e.g && yellow === e.y && red === e.r &&
                remaining === e.rem && active_phase === e.act) begin
                passed++;
            end else begin
                $display("FAIL %s: got g=%b y=%b r=%b rem=%0d act=%0d, want g=%b y=%b r=%b rem=%0d act=%0d",
                         tag, green, yellow, red, remaining, active_phase,
                         e.g, e.y, e.r, e.rem, e.act);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 4'b1111, "G", 0, 8};
        vecs[1]  = '{1'b0, 1'b1, 4'b0100, "G", 0, 7};
        vecs[2]  = '{1'b0, 1'b1, 4'b0000, "G", 0, 6};
        vecs[3]  = '{1'b0, 1'b1, 4'b0000, "Y", 0, 2};
        vecs[4]  = '{1'b0, 1'b1, 4'b0000, "Y", 0, 1};
        vecs[5]  = '{1'b0, 1'b1, 4'b0000, "A", 0, 1};
        vecs[6]  = '{1'b0, 1'b1, 4'b0000, "G", 2, 8};
        vecs[7]  = '{1'b0, 1'b0, 4'b0000, "G", 2, 8};
        vecs[8]  = '{1'b0, 1'b1, 4'b0000, "G", 2, 7};
        vecs[9]  = '{1'b0, 1'b1, 4'b0010, "G", 2, 6};
        vecs[10] = '{1'b0, 1'b1, 4'b0000, "Y", 2, 2};
        vecs[11] = '{1'b0, 1'b1, 4'b0000, "Y", 2, 1};
        vecs[12] = '{1'b1, 1'b1, 4'b0000, "G", 0, 8};
        vecs[13] = '{1'b0, 1'b1, 4'b0000, "G", 0, 7};
        vecs[14] = '{1'b0, 1'b1, 4'b0001, "G", 0, 6};
        vecs[15] = '{1'b0, 1'b1, 4'b0000, "G", 0, 5};
        vecs[16] = '{1'b0, 1'b1, 4'b0000, "G", 0, 4};

        repeat (2) @(posedge clk);
        #1;

        // Single call on phase 2, tick gating, reset mid-yellow, own-phase demand ignored in green.
        for (int i = 0; i < 17; i++) begin
            step(vecs[i].rst, vecs[i].tk, vecs[i].dm, vecs[i].st, vecs[i].ph, vecs[i].rem,
                 $sformatf("vec%0d", i));
        end

        // No demand: phase 0 rests in green, remaining saturates at zero.
        step(1'b1, 1'b1, 4'b0, "G", 0, 8, "idle_reset");
        for (int k = 1; k <= 50; k++) begin
            step(1'b0, 1'b1, 4'b0, "G", 0, (k >= 8) ? 0 : 8 - k, $sformatf("idle%0d", k));
        end

        // Held own demand with a conflicting call: green runs to MAX_GREEN exactly.
        step(1'b1, 1'b1, 4'b0, "G", 0, 8, "maxg_reset");
        step(1'b0, 1'b1, 4'b0011, "G", 0, 7, "maxg1");
        for (int k = 2; k <= 7; k++) begin
            step(1'b0, 1'b1, 4'b0001, "G", 0, 8 - k, $sformatf("maxg%0d", k));
        end
        step(1'b0, 1'b1, 4'b0001, "Y", 0, 2, "maxg_yellow");

        // Simultaneous calls on 1 and 3 during phase 2 green: 3 served before 1.
        step(1'b1, 1'b1, 4'b0, "G", 0, 8, "rr_reset");
        step(1'b0, 1'b1, 4'b0100, "G", 0, 7, "rr1");
        step(1'b0, 1'b1, 4'b0000, "G", 0, 6, "rr2");
        step(1'b0, 1'b1, 4'b0000, "Y", 0, 2, "rr3");
        step(1'b0, 1'b1, 4'b0000, "Y", 0, 1, "rr4");
        step(1'b0, 1'b1, 4'b0000, "A", 0, 1, "rr5");
        step(1'b0, 1'b1, 4'b0000, "G", 2, 8, "rr6");
        step(1'b0, 1'b1, 4'b1010, "G", 2, 7, "rr7");
        step(1'b0, 1'b1, 4'b0000, "G", 2, 6, "rr8");
        step(1'b0, 1'b1, 4'b0000, "Y", 2, 2, "rr9");
        step(1'b0, 1'b1, 4'b0000, "Y", 2, 1, "rr10");
        step(1'b0, 1'b1, 4'b0000, "A", 2, 1, "rr11");
        step(1'b0, 1'b1, 4'b0000, "G", 3, 8, "rr12_phase3");
        step(1'b0, 1'b1, 4'b0000, "G", 3, 7, "rr13");
        step(1'b0, 1'b1, 4'b0000, "G", 3, 6, "rr14");
        step(1'b0, 1'b1, 4'b0000, "Y", 3, 2, "rr15");
        step(1'b0, 1'b1, 4'b0000, "Y", 3, 1, "rr16");
        step(1'b0, 1'b1, 4'b0000, "A", 3, 1, "rr17");
        step(1'b0, 1'b1, 4'b0000, "G", 1, 8, "rr18_phase1");

`ifdef TRAFFIC_PREEMPT_EN
        // Preempt one tick into phase 1 green: immediate yellow, then phase 0 held.
        step(1'b1, 1'b1, 4'b0, "G", 0, 8, "pre_reset");
        step(1'b0, 1'b1, 4'b0010, "G", 0, 7, "pre1");
        step(1'b0, 1'b1, 4'b0000, "G", 0, 6, "pre2");
        step(1'b0, 1'b1, 4'b0000, "Y", 0, 2, "pre3");
        step(1'b0, 1'b1, 4'b0000, "Y", 0, 1, "pre4");
        step(1'b0, 1'b1, 4'b0000, "A", 0, 1, "pre5");
        step(1'b0, 1'b1, 4'b0000, "G", 1, 8, "pre6");
        step(1'b0, 1'b1, 4'b0000, "G", 1, 7, "pre7");
        preempt = 1'b1;
        step(1'b0, 1'b1, 4'b0000, "Y", 1, 2, "pre_yellow");
        step(1'b0, 1'b1, 4'b0000, "Y", 1, 1, "pre9");
        step(1'b0, 1'b1, 4'b0000, "A", 1, 1, "pre_allred");
        step(1'b0, 1'b1, 4'b0000, "G", 0, 8, "pre_green0");
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b1, 4'b0100, "G", 0, (k >= 8) ? 0 : 8 - k, $sformatf("pre_hold%0d", k));
        end
        preempt = 1'b0;
        step(1'b0, 1'b1, 4'b0000, "Y", 0, 2, "pre_release");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
